aes_192_result_buffer: RTL and testbench

- Sits directly downstream of the AES-192 mock-TSS wrapper, between it and the register/bus interface.
- Issues the single-cycle core start using a credit scheme.
- Counts in-flight operations and captures each 128-bit out / out_valid result into a small first-word-fall-through FIFO.
- Software drains the FIFO with a valid/ready handshake and never loses a result.

---
 rtl/aes_192_result_buffer.sv | 117 +++++++++++
 tb/tb_aes_192_result_buffer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_192_result_buffer.sv
// AES-192 result buffer: credit-gated core start, in-flight tracking,
// and a first-word-fall-through result FIFO drained by valid/ready.
module aes_192_result_buffer #(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 128,
    localparam int CNT_W     = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_req,
    output logic                  start_ack,
    output logic                  core_start,
    input  logic [DATA_WIDTH-1:0] core_out,
    input  logic                  core_out_valid,
    output logic [DATA_WIDTH-1:0] result_data,
    output logic                  result_valid,
    input  logic                  result_ready,
    input  logic                  clear,
    output logic [CNT_W-1:0]      fifo_count,
    output logic [CNT_W-1:0]      inflight,
    output logic                  overflow_err,
    output logic                  unexpected_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W:0] DEPTH_W = DEPTH[CNT_W:0];
    localparam logic [CNT_W-1:0] FULL_CNT = DEPTH[CNT_W-1:0];

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count_q;
    logic [CNT_W-1:0]      inflight_q;
    logic                  ovf_q;
    logic                  unx_q;

    logic [CNT_W:0] credit_used;
    logic           full;
    logic           empty;
    logic           pop;
    logic           push_req;
    logic           push;
    logic           ovf_set;
    logic           unx_set;

    // Credit covers both in-flight ops and buffered results, so a
    // well-behaved core can never overrun the FIFO.
    assign credit_used = {1'b0, inflight_q} + {1'b0, count_q};
    assign start_ack   = start_req && (credit_used < DEPTH_W) && !clear && !rst;
    assign core_start  = start_ack;

    assign full     = (count_q == FULL_CNT);
    assign empty    = (count_q == '0);
    assign pop      = !empty && result_ready;
    assign push_req = core_out_valid && !clear;
    assign push     = push_req && (!full || pop);
    assign ovf_set  = push_req && full && !pop;
    assign unx_set  = core_out_valid && (inflight_q == '0);

    assign result_data    = mem[rd_ptr];
    assign result_valid   = !empty;
    assign fifo_count     = count_q;
    assign inflight       = inflight_q;
    assign overflow_err   = ovf_q;
    assign unexpected_err = unx_q;

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr] <= core_out;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            inflight_q <= '0;
            ovf_q      <= 1'b0;
            unx_q      <= 1'b0;
        end else begin
            // Results keep returning through a clear, so inflight tracks them.
            if (start_ack && !core_out_valid) begin
                inflight_q <= inflight_q + 1'b1;
            end else if (!start_ack && core_out_valid && inflight_q != '0) begin
                inflight_q <= inflight_q - 1'b1;
            end

            if (clear) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                count_q <= '0;
                ovf_q   <= 1'b0;
                unx_q   <= 1'b0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                if (push && !pop) begin
                    count_q <= count_q + 1'b1;
                end else if (pop && !push) begin
                    count_q <= count_q - 1'b1;
                end
                if (ovf_set) begin
                    ovf_q <= 1'b1;
                end
                if (unx_set) begin
                    unx_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_aes_192_result_buffer.sv
// Directed bench for aes_192_result_buffer: vector table plus
// hand-written multi-cycle sequences.
module tb_aes_192_result_buffer;

    localparam int DW = 128;
    localparam logic [DW-1:0] DA = 128'h3243F6A8_885A308D_313198A2_E0370734;

    logic          clk;
    logic          rst;
    logic          start_req;
    logic          start_ack;
    logic          core_start;
    logic [DW-1:0] core_out;
    logic          core_out_valid;
    logic [DW-1:0] result_data;
    logic          result_valid;
    logic          result_ready;
    logic          clear;
    logic [2:0]    fifo_count;
    logic [2:0]    inflight;
    logic          overflow_err;
    logic          unexpected_err;

    int n_chk;
    int n_fail;
    int pulses;

    aes_192_result_buffer dut (
        .clk           (clk),
        .rst           (rst),
        .start_req     (start_req),
        .start_ack     (start_ack),
        .core_start    (core_start),
        .core_out      (core_out),
        .core_out_valid(core_out_valid),
        .result_data   (result_data),
        .result_valid  (result_valid),
        .result_ready  (result_ready),
        .clear         (clear),
        .fifo_count    (fifo_count),
        .inflight      (inflight),
        .overflow_err  (overflow_err),
        .unexpected_err(unexpected_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          sr;
        logic          cov;
        logic [DW-1:0] d;
        logic          rdy;
        logic          clr;
        logic          rs;
        logic          e_ack;
        logic          e_valid;
        logic [DW-1:0] e_data;
        logic [2:0]    e_cnt;
        logic [2:0]    e_inf;
        logic          e_ovf;
        logic          e_unx;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic sr, input logic cov, input logic [DW-1:0] d,
                         input logic rdy, input logic clr, input logic rs);
        start_req      = sr;
        core_out_valid = cov;
        core_out       = d;
        result_ready   = rdy;
        clear          = clr;
        rst            = rs;
    endtask

    task automatic do_reset();
        drive(0, 0, '0, 0, 0, 1);
        tick();
        drive(0, 0, '0, 0, 0, 0);
    endtask

    initial begin
        clk = 0;
        n_chk = 0;
        n_fail = 0;
        drive(0, 0, '0, 0, 0, 1);
        tick();
        tick();

        //            sr cov d        rdy clr rs ack val data   cnt inf ovf unx
        vecs[0] = '{1, 0, '0,       0, 0, 1, 0, 0, '0,     0, 0, 0, 0};
        vecs[1] = '{1, 0, '0,       0, 0, 0, 1, 0, '0,     0, 1, 0, 0};
        vecs[2] = '{0, 0, '0,       0, 0, 0, 0, 0, '0,     0, 1, 0, 0};
        vecs[3] = '{0, 1, DA,       0, 0, 0, 0, 1, DA,     1, 0, 0, 0};
        vecs[4] = '{0, 0, '0,       1, 0, 0, 0, 0, '0,     0, 0, 0, 0};
        vecs[5] = '{0, 1, 128'hB,   0, 0, 0, 0, 1, 128'hB, 1, 0, 0, 1};
        vecs[6] = '{1, 0, '0,       0, 1, 0, 0, 0, '0,     0, 0, 0, 0};
        vecs[7] = '{1, 1, 128'hC,   0, 0, 0, 1, 1, 128'hC, 1, 0, 0, 1};
        vecs[8] = '{1, 0, '0,       1, 0, 0, 1, 0, '0,     0, 1, 0, 1};
        vecs[9] = '{1, 0, '0,       0, 0, 1, 0, 0, '0,     0, 0, 0, 0};

        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].sr, vecs[i].cov, vecs[i].d, vecs[i].rdy,
                  vecs[i].clr, vecs[i].rs);
            #1;
            chk($sformatf("v%0d start_ack", i), start_ack, vecs[i].e_ack);
            chk($sformatf("v%0d core_start", i), core_start, vecs[i].e_ack);
            tick();
            chk($sformatf("v%0d result_valid", i), result_valid, vecs[i].e_valid);
            if (vecs[i].e_valid)
                chk($sformatf("v%0d result_data", i), result_data, vecs[i].e_data);
            chk($sformatf("v%0d fifo_count", i), fifo_count, vecs[i].e_cnt);
            chk($sformatf("v%0d inflight", i), inflight, vecs[i].e_inf);
            chk($sformatf("v%0d overflow_err", i), overflow_err, vecs[i].e_ovf);
            chk($sformatf("v%0d unexpected_err", i), unexpected_err, vecs[i].e_unx);
        end

        // Single operation with 10-cycle core latency
        do_reset();
        pulses = 0;
        drive(1, 0, '0, 0, 0, 0);
        #1;
        if (core_start) pulses++;
        tick();
        chk("t1 inflight up", inflight, 1);
        drive(0, 0, '0, 0, 0, 0);
        for (int k = 0; k < 9; k++) begin
            #1;
            if (core_start) pulses++;
            tick();
        end
        chk("t1 inflight held", inflight, 1);
        drive(0, 1, DA, 0, 0, 0);
        #1;
        chk("t1 valid before edge", result_valid, 0);
        tick();
        drive(0, 0, '0, 0, 0, 0);
        chk("t1 valid", result_valid, 1);
        chk("t1 data", result_data, DA);
        chk("t1 inflight down", inflight, 0);
        chk("t1 start pulses", pulses, 1);

        // Credit exhaustion with held start_req
        do_reset();
        pulses = 0;
        drive(1, 0, '0, 0, 0, 0);
        for (int k = 0; k < 8; k++) begin
            #1;
            if (core_start) pulses++;
            tick();
        end
        chk("t2 start pulses", pulses, 4);
        chk("t2 inflight full", inflight, 4);
        #1;
        chk("t2 ack blocked", start_ack, 0);
        for (int k = 0; k < 4; k++) begin
            drive(1, 1, 128'h100 + DW'(k), 0, 0, 0);
            #1;
            if (core_start) pulses++;
            tick();
        end
        chk("t2 fifo_count", fifo_count, 4);
        chk("t2 inflight drained", inflight, 0);
        chk("t2 no extra starts", pulses, 4);
        pulses = 0;
        drive(1, 0, '0, 1, 0, 0);
        #1;
        if (core_start) pulses++;
        tick();
        drive(1, 0, '0, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            #1;
            if (core_start) pulses++;
            tick();
        end
        chk("t2 one more start", pulses, 1);
        chk("t2 inflight after pop", inflight, 1);
        chk("t2 count after pop", fifo_count, 3);
        drive(0, 1, 128'h200, 0, 0, 0);
        tick();
        chk("t2 refilled", fifo_count, 4);

        // Overflow from a misbehaving core
        drive(0, 1, 128'hDEAD, 0, 0, 0);
        tick();
        chk("t3 overflow_err", overflow_err, 1);
        chk("t3 unexpected_err", unexpected_err, 1);
        chk("t3 count held", fifo_count, 4);
        chk("t3 head kept", result_data, 128'h101);

        // Full with simultaneous push and pop
        drive(0, 1, 128'hBEEF, 1, 0, 0);
        tick();
        chk("t4 count full", fifo_count, 4);
        chk("t4 head next", result_data, 128'h102);
        drive(0, 0, '0, 0, 1, 0);
        tick();
        chk("t4 cleared count", fifo_count, 0);
        chk("t4 cleared ovf", overflow_err, 0);

        // Ordering across pointer wrap, values 1..10
        for (int k = 1; k <= 3; k++) begin
            drive(0, 1, DW'(k), 0, 0, 0);
            tick();
        end
        for (int k = 4; k <= 10; k++) begin
            drive(0, 1, DW'(k), 1, 0, 0);
            #1;
            chk($sformatf("t4 order %0d", k - 3), result_data, DW'(k - 3));
            tick();
        end
        for (int k = 8; k <= 10; k++) begin
            drive(0, 0, '0, 1, 0, 0);
            #1;
            chk($sformatf("t4 drain valid %0d", k), result_valid, 1);
            chk($sformatf("t4 order %0d", k), result_data, DW'(k));
            tick();
        end
        drive(0, 0, '0, 0, 0, 0);
        chk("t4 empty", result_valid, 0);

        // Clear with results buffered and operations in flight
        do_reset();
        drive(1, 0, '0, 0, 0, 0);
        for (int k = 0; k < 4; k++) tick();
        drive(0, 1, 128'h11, 0, 0, 0);
        tick();
        drive(0, 1, 128'h22, 0, 0, 0);
        tick();
        chk("t5 count before", fifo_count, 2);
        drive(0, 0, '0, 0, 1, 0);
        tick();
        chk("t5 count cleared", fifo_count, 0);
        chk("t5 valid cleared", result_valid, 0);
        chk("t5 ovf cleared", overflow_err, 0);
        chk("t5 unx cleared", unexpected_err, 0);
        chk("t5 inflight kept", inflight, 2);
        drive(0, 1, 128'h33, 0, 0, 0);
        tick();
        drive(0, 1, 128'h44, 0, 0, 0);
        tick();
        drive(0, 0, '0, 0, 0, 0);
        chk("t5 count after", fifo_count, 2);
        chk("t5 inflight after", inflight, 0);
        chk("t5 unx after", unexpected_err, 0);
        chk("t5 head after", result_data, 128'h33);

        // Reset mid-operation
        do_reset();
        drive(1, 0, '0, 0, 0, 0);
        for (int k = 0; k < 4; k++) tick();
        drive(0, 1, 128'h55, 0, 0, 0);
        tick();
        chk("t6 inflight before", inflight, 3);
        chk("t6 count before", fifo_count, 1);
        drive(1, 0, '0, 0, 0, 1);
        #1;
        chk("t6 ack in reset", start_ack, 0);
        tick();
        chk("t6 valid", result_valid, 0);
        chk("t6 count", fifo_count, 0);
        chk("t6 inflight", inflight, 0);
        chk("t6 ovf", overflow_err, 0);
        chk("t6 unx", unexpected_err, 0);
        drive(0, 1, 128'h66, 0, 0, 0);
        tick();
        drive(0, 0, '0, 0, 0, 0);
        chk("t6 unx late result", unexpected_err, 1);
        chk("t6 late pushed", fifo_count, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
